uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Receive-side UART core; the counterpart of the TX serializer path.
- Oversamples the asynchronous serial line RX_IN at PRESCALE clocks per bit, finds the start bit, and majority-votes each bit.
- Deserializes LSB-first data, checks optional parity and the stop bit, and presents a parallel byte with a one-cycle valid pulse.
- Sits in the UART block on the UART clock domain; feeds the RX-side data synchronizer.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_W, 6, width of the PRESCALE input and the edge counter.

Ports:
- CLK  in  1  oversampling clock.
- RST  in  1  reset, asynchronous, active-low.
- RX_IN  in  1  serial line, idle high.
- PRESCALE  in  PRESCALE_W  clocks per bit; even, 8..2^PRESCALE_W-2.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- P_DATA  out  DATA_WIDTH  received byte.
- DATA_VALID  out  1  one-cycle pulse when a frame is good.
- PAR_ERR  out  1  one-cycle pulse on parity mismatch.
- STP_ERR  out  1  one-cycle pulse on bad stop bit.

Behaviour:
- Reset: FSM goes to IDLE; all counters 0. P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0. Reset mid-frame aborts the frame silently.
- Configuration latch: PRESCALE, PAR_EN and PAR_TYP are captured on start detection and held for the whole frame. Changes mid-frame are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - RX_IN=0 in a cycle (cycle 0) moves the FSM to START, with edge_cnt=1 on the next cycle.
  - Bit k of the frame occupies cycles k*P .. k*P+P-1 (P = latched PRESCALE).
- Edge counter: runs 0..P-1 and wraps to 0 at P-1. The bit transition happens on the cycle where edge_cnt==P-1.
- Sampling:
  - RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - Bit value is the 2-of-3 majority, valid from edge_cnt = P/2+2.
- START: if the voted value is 1, this is a glitch. Return to IDLE at the end of the bit, with no output pulse.
- DATA:
  - DATA_WIDTH bits, LSB first, shifted into an internal register.
  - Bit counter 0..DATA_WIDTH-1. After the last bit, go to PARITY if PAR_EN else STOP.
- PARITY:
  - Expected value = XOR of the data bits, XOR PAR_TYP.
  - On mismatch, set a sticky per-frame flag and pulse PAR_ERR in the cycle after the last edge of the parity bit.
- STOP:
  - If the voted value is 0, pulse STP_ERR at the same relative cycle.
  - At the end of the stop bit:
    - If there is no parity error and no stop error, load P_DATA from the shift register and pulse DATA_VALID in cycle N*P (N=10, or 11 with parity).
    - Otherwise P_DATA keeps its old value and DATA_VALID stays 0.
- P_DATA holds its value until the next good frame.
- Back-to-back frames:
  - After STOP, the FSM re-enters IDLE. Cycle N*P may itself be the start-detect cycle of the next frame, with no dead cycle required.
  - A valid pulse and a new start detection in the same cycle are legal.
- Line held low (break): reported as STP_ERR, then a new frame starts immediately since RX_IN=0 in IDLE.
- Outputs are registered; there is no combinational path from RX_IN to any output.

Optional Feature:
- Macro UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer (reset value 1) before the FSM. All timings above shift by +2 cycles relative to the pin.
- Undefined: RX_IN is used directly; the synchronizer is instantiated upstream.

Decomposition:
- Shared uart_pkg:
  - FSM state encoding (enum).
  - Default DATA_WIDTH and PRESCALE_W constants.
  - Parity-type constants PAR_EVEN=0, PAR_ODD=1.
- Sub-module uart_rx_sampler:
  - Contains the edge counter and the 3-sample majority vote.
  - Outputs bit_done (edge_cnt==P-1) and sampled_bit.
- The top level holds the FSM, bit counter, shift register and checks.

Test Plan:
- P=8, PAR_EN=0, send 0xA5 with stop=1 -> DATA_VALID pulse in cycle 80, P_DATA=0xA5, no errors.
- P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> valid in cycle 176, P_DATA=0x3C. Repeat with parity bit 1 -> PAR_ERR pulse in cycle 160, no DATA_VALID, P_DATA unchanged.
- P=8, stop bit driven 0 for 0x55 -> STP_ERR in cycle 80, no DATA_VALID. Line kept low afterwards -> next frame starts at cycle 80.
- P=16, RX_IN low for 3 cycles then high (glitch) -> FSM back in IDLE by cycle 16, no output pulses. A following real frame 0x81 is received correctly.
- P=32, one-cycle spikes at sample points P/2 of every data bit of 0xF0 -> majority vote still yields P_DATA=0xF0.
- P=8, two back-to-back frames 0x01 and 0xFE, then RST asserted at cycle 40 of a third frame -> two valid pulses at cycles 80 and 160. After reset: outputs 0, FSM in IDLE, no pulse for the aborted frame.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART block: receive FSM state encoding, default
// frame geometry and parity-type constants.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;  // payload bits per frame
    localparam int DEF_PRESCALE_W = 6;  // width of PRESCALE and the edge counter

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Oversampling edge counter and 3-point majority vote for one serial bit.
//
// Ports:
//   CLK, RST     clock, asynchronous active-low reset
//   rx_bit       serial line (already synchronized where required)
//   start        start-edge detected this cycle; edge counter restarts at 1
//   active       a frame is in progress (FSM not idle)
//   prescale     latched clocks-per-bit value P
//   bit_done     edge_cnt == P-1 while active: last cycle of the current bit
//   sampled_bit  2-of-3 majority of the samples at P/2-1, P/2, P/2+1
// ---------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_bit,
    input  logic                  start,
    input  logic                  active,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_done,
    output logic                  sampled_bit
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] mid_edge;
    logic [2:0]            samples;

    assign last_edge = prescale - ONE;
    assign mid_edge  = prescale >> 1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            samples  <= '0;
        end else begin
            // The start-detect cycle is edge 0 of the start bit, so the
            // counter resumes at 1 on the following cycle.
            if (start)
                edge_cnt <= ONE;
            else if (!active || edge_cnt == last_edge)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + ONE;

            if (active) begin
                if (edge_cnt == mid_edge - ONE) samples[0] <= rx_bit;
                if (edge_cnt == mid_edge)       samples[1] <= rx_bit;
                if (edge_cnt == mid_edge + ONE) samples[2] <= rx_bit;
            end
        end
    end

    assign bit_done    = active && (edge_cnt == last_edge);
    assign sampled_bit = (samples[0] & samples[1]) |
                         (samples[0] & samples[2]) |
                         (samples[1] & samples[2]);

endmodule : uart_rx_sampler

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Receive-side UART core. Oversamples RX_IN at PRESCALE clocks per bit,
// detects the start bit, majority-votes each bit, deserializes LSB first,
// checks optional parity and the stop bit, and presents the byte on P_DATA
// with a one-cycle DATA_VALID pulse.
//
// Ports:
//   CLK         oversampling clock
//   RST         asynchronous active-low reset
//   RX_IN       serial line, idle high
//   PRESCALE    clocks per bit (even, 8 .. 2^PRESCALE_W-2)
//   PAR_EN      frame carries a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   P_DATA      last good received byte
//   DATA_VALID  one-cycle pulse for a good frame
//   PAR_ERR     one-cycle pulse on parity mismatch
//   STP_ERR     one-cycle pulse on a bad stop bit
//
// Build option:
//   UART_RX_SYNC_EN  when defined, RX_IN passes through a local 2-flop
//                    synchronizer (all timings +2 cycles); otherwise the
//                    synchronizer lives upstream and RX_IN is used directly.
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic rx_line;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Reset to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], RX_IN};
    end

    assign rx_line = sync_q[1];
`else
    assign rx_line = RX_IN;
`endif

    rx_state_t             state;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_err_q;   // sticky parity error for this frame

    logic start_det;
    logic active;
    logic bit_done;
    logic sampled_bit;

    assign start_det = (state == ST_IDLE) && !rx_line;
    assign active    = (state != ST_IDLE);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .rx_bit      (rx_line),
        .start       (start_det),
        .active      (active),
        .prescale    (prescale_q),
        .bit_done    (bit_done),
        .sampled_bit (sampled_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses unless re-asserted below.
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (start_det) begin
                        // Frame configuration is frozen for the whole frame.
                        prescale_q <= PRESCALE;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        bit_cnt    <= '0;
                        par_err_q  <= 1'b0;
                        state      <= ST_START;
                    end
                end

                ST_START: begin
                    if (bit_done)
                        state <= sampled_bit ? ST_IDLE : ST_DATA;
                end

                ST_DATA: begin
                    if (bit_done) begin
                        shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_PARITY: begin
                    if (bit_done) begin
                        if (sampled_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD))) begin
                            par_err_q <= 1'b1;
                            PAR_ERR   <= 1'b1;
                        end
                        state <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (bit_done) begin
                        if (!sampled_bit)
                            STP_ERR <= 1'b1;
                        if (sampled_bit && !par_err_q) begin
                            P_DATA     <= shift_q;
                            DATA_VALID <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed self-checking bench for uart_rx. Frame cycle 0 is the cycle in
// which the start bit first appears on RX_IN; every expected pulse cycle is
// computed as frame_start + bits*P (+2 when the local synchronizer is built).
// ---------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    uart_rx #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    // Pulse monitor: records the cycle of every output pulse and the byte seen.
    int dv_q[$];
    int dvd_q[$];
    int pe_q[$];
    int se_q[$];
    int sed_q[$];

    always @(negedge CLK) begin
        if (DATA_VALID) begin dv_q.push_back(cyc); dvd_q.push_back(int'(P_DATA)); end
        if (PAR_ERR)    pe_q.push_back(cyc);
        if (STP_ERR)    begin se_q.push_back(cyc); sed_q.push_back(int'(P_DATA)); end
    end

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_mon();
        dv_q.delete(); dvd_q.delete(); pe_q.delete(); se_q.delete(); sed_q.delete();
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives one bit for p cycles; optionally inverts the centre sample cycle.
    task automatic drive_bit(input logic v, input int p, input bit spike);
        for (int c = 0; c < p; c++) begin
            RX_IN = (spike && c == p / 2) ? ~v : v;
            @(posedge CLK);
            #1;
        end
    endtask

    // Full frame. Configuration inputs are scrambled after the start bit to
    // show they are only used as captured at start detection.
    task automatic send_frame(input logic [7:0] data, input int p, input bit par_en,
                              input bit par_typ, input bit par_bit, input bit stop_bit,
                              input bit spike, output int t0);
        PRESCALE = 6'(p);
        PAR_EN   = par_en;
        PAR_TYP  = par_typ;
        t0 = cyc;
        drive_bit(1'b0, p, 1'b0);
        PRESCALE = 6'd12;
        PAR_EN   = ~par_en;
        PAR_TYP  = ~par_typ;
        for (int i = 0; i < 8; i++) drive_bit(data[i], p, spike);
        if (par_en) drive_bit(par_bit, p, 1'b0);
        drive_bit(stop_bit, p, 1'b0);
    endtask

    task automatic test_reset();
        RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (P_DATA !== 8'h00) $display("FAIL reset_p_data: got %h want 00", P_DATA); else passed++;
        total++; if (DATA_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", DATA_VALID); else passed++;
        total++; if (PAR_ERR !== 1'b0) $display("FAIL reset_par_err: got %b want 0", PAR_ERR); else passed++;
        total++; if (STP_ERR !== 1'b0) $display("FAIL reset_stp_err: got %b want 0", STP_ERR); else passed++;
        RST = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        int t0;
        clear_mon();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        idle(4);
        total++; if (dv_q.size() !== 1) $display("FAIL basic_dv_count: got %0d want 1", dv_q.size()); else passed++;
        total++; if (q_at(dv_q, 0) !== t0 + 80 + LAT) $display("FAIL basic_dv_cycle: got %0d want %0d", q_at(dv_q, 0) - t0, 80 + LAT); else passed++;
        total++; if (P_DATA !== 8'hA5) $display("FAIL basic_p_data: got %h want a5", P_DATA); else passed++;
        total++; if (pe_q.size() + se_q.size() !== 0) $display("FAIL basic_no_err: got %0d error pulses want 0", pe_q.size() + se_q.size()); else passed++;
    endtask

    task automatic test_parity();
        int t0;
        // Even parity, correct parity bit.
        clear_mon();
        send_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0, t0);
        idle(4);
        total++; if (q_at(dv_q, 0) !== t0 + 176 + LAT) $display("FAIL par_ok_dv_cycle: got %0d want %0d", q_at(dv_q, 0) - t0, 176 + LAT); else passed++;
        total++; if (P_DATA !== 8'h3C) $display("FAIL par_ok_p_data: got %h want 3c", P_DATA); else passed++;
        total++; if (pe_q.size() !== 0) $display("FAIL par_ok_no_pe: got %0d want 0", pe_q.size()); else passed++;
        // Same byte, wrong parity bit.
        clear_mon();
        send_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0, t0);
        idle(4);
        total++; if (q_at(pe_q, 0) !== t0 + 160 + LAT) $display("FAIL par_bad_pe_cycle: got %0d want %0d", q_at(pe_q, 0) - t0, 160 + LAT); else passed++;
        total++; if (dv_q.size() !== 0) $display("FAIL par_bad_no_dv: got %0d want 0", dv_q.size()); else passed++;
        total++; if (se_q.size() !== 0) $display("FAIL par_bad_no_se: got %0d want 0", se_q.size()); else passed++;
        // Different byte with wrong parity: P_DATA must still hold 0x3C.
        clear_mon();
        send_frame(8'h5A, 16, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0, t0);
        idle(4);
        total++; if (pe_q.size() !== 1) $display("FAIL par_bad2_pe_count: got %0d want 1", pe_q.size()); else passed++;
        total++; if (P_DATA !== 8'h3C) $display("FAIL par_bad2_hold: got %h want 3c", P_DATA); else passed++;
        // Odd parity: 0x07 has three ones, so the parity bit is 0.
        clear_mon();
        send_frame(8'h07, 16, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0, t0);
        idle(4);
        total++; if (q_at(dv_q, 0) !== t0 + 176 + LAT) $display("FAIL par_odd_dv_cycle: got %0d want %0d", q_at(dv_q, 0) - t0, 176 + LAT); else passed++;
        total++; if (P_DATA !== 8'h07) $display("FAIL par_odd_p_data: got %h want 07", P_DATA); else passed++;
    endtask

    task automatic test_stop_break();
        int t0, t1;
        clear_mon();
        // Bad stop bit, then the line stays low through the next frame's
        // start and data bits (0x00) before a good stop bit.
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t0);
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t1);
        idle(4);
        total++; if (q_at(se_q, 0) !== t0 + 80 + LAT) $display("FAIL stop_se_cycle: got %0d want %0d", q_at(se_q, 0) - t0, 80 + LAT); else passed++;
        total++; if (q_at(sed_q, 0) !== 32'h07) $display("FAIL stop_hold: got %h want 07", q_at(sed_q, 0)); else passed++;
        total++; if (dv_q.size() !== 1) $display("FAIL break_dv_count: got %0d want 1", dv_q.size()); else passed++;
        total++; if (q_at(dv_q, 0) !== t0 + 160 + LAT) $display("FAIL break_dv_cycle: got %0d want %0d", q_at(dv_q, 0) - t0, 160 + LAT); else passed++;
        total++; if (P_DATA !== 8'h00) $display("FAIL break_p_data: got %h want 00", P_DATA); else passed++;
    endtask

    task automatic test_glitch();
        int t0;
        clear_mon();
        PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        RX_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        @(negedge CLK);
        total++; if (dut.state !== ST_START) $display("FAIL glitch_start: got %0d want %0d", dut.state, ST_START); else passed++;
        @(posedge CLK);
        #1;
        repeat (12 + LAT) @(posedge CLK);
        #1;
        @(negedge CLK);
        total++; if (dut.state !== ST_IDLE) $display("FAIL glitch_idle: got %0d want %0d", dut.state, ST_IDLE); else passed++;
        @(posedge CLK);
        #1;
        idle(40);
        total++; if (dv_q.size() + pe_q.size() + se_q.size() !== 0) $display("FAIL glitch_no_pulse: got %0d pulses want 0", dv_q.size() + pe_q.size() + se_q.size()); else passed++;
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        idle(4);
        total++; if (q_at(dv_q, 0) !== t0 + 160 + LAT) $display("FAIL glitch_next_dv_cycle: got %0d want %0d", q_at(dv_q, 0) - t0, 160 + LAT); else passed++;
        total++; if (P_DATA !== 8'h81) $display("FAIL glitch_next_p_data: got %h want 81", P_DATA); else passed++;
    endtask

    task automatic test_spike();
        int t0;
        clear_mon();
        send_frame(8'hF0, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t0);
        idle(4);
        total++; if (q_at(dv_q, 0) !== t0 + 320 + LAT) $display("FAIL spike_dv_cycle: got %0d want %0d", q_at(dv_q, 0) - t0, 320 + LAT); else passed++;
        total++; if (P_DATA !== 8'hF0) $display("FAIL spike_p_data: got %h want f0", P_DATA); else passed++;
    endtask

    task automatic test_back_to_back();
        int t0, t1, t2;
        logic [7:0] d3;
        clear_mon();
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        send_frame(8'hFE, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t1);
        // Third frame aborted by reset at its cycle 40.
        d3 = 8'h33;
        PRESCALE = 6'd8;
        t2 = cyc;
        drive_bit(1'b0, 8, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d3[i], 8, 1'b0);
        total++; if (t2 - t0 !== 160) $display("FAIL b2b_frame3_start: got %0d want 160", t2 - t0); else passed++;
        RST = 1'b0;
        RX_IN = 1'b1;
        #1;
        total++; if (P_DATA !== 8'h00) $display("FAIL b2b_reset_p_data: got %h want 00", P_DATA); else passed++;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(100);
        total++; if (dv_q.size() !== 2) $display("FAIL b2b_dv_count: got %0d want 2", dv_q.size()); else passed++;
        total++; if (q_at(dv_q, 0) !== t0 + 80 + LAT) $display("FAIL b2b_dv0_cycle: got %0d want %0d", q_at(dv_q, 0) - t0, 80 + LAT); else passed++;
        total++; if (q_at(dv_q, 1) !== t0 + 160 + LAT) $display("FAIL b2b_dv1_cycle: got %0d want %0d", q_at(dv_q, 1) - t0, 160 + LAT); else passed++;
        total++; if (q_at(dvd_q, 0) !== 32'h01) $display("FAIL b2b_dv0_data: got %h want 01", q_at(dvd_q, 0)); else passed++;
        total++; if (q_at(dvd_q, 1) !== 32'hFE) $display("FAIL b2b_dv1_data: got %h want fe", q_at(dvd_q, 1)); else passed++;
        total++; if (dut.state !== ST_IDLE) $display("FAIL b2b_reset_idle: got %0d want %0d", dut.state, ST_IDLE); else passed++;
        total++; if (P_DATA !== 8'h00) $display("FAIL b2b_after_reset_p_data: got %h want 00", P_DATA); else passed++;
        total++; if (pe_q.size() + se_q.size() !== 0) $display("FAIL b2b_no_err: got %0d error pulses want 0", pe_q.size() + se_q.size()); else passed++;
        // Receiver recovers fully after the abort.
        clear_mon();
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        idle(4);
        total++; if (q_at(dv_q, 0) !== t0 + 80 + LAT) $display("FAIL recover_dv_cycle: got %0d want %0d", q_at(dv_q, 0) - t0, 80 + LAT); else passed++;
        total++; if (P_DATA !== 8'hC3) $display("FAIL recover_p_data: got %h want c3", P_DATA); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop_break();
        test_glitch();
        test_spike();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_uart_rx
